// File: rtl/dsp_block6_pkg.sv
// rtl/dsp_block6_pkg.sv - shared geometry, widths, FSM encodings and tap addressing for the strip-6 conv engine
package dsp_block6_pkg;
  localparam int KSIZE  = 3;
  localparam int IMG_W  = 224;
  localparam int IMG_H  = 30;
  localparam int OUT_W  = IMG_W - KSIZE + 1;
  localparam int OUT_H  = IMG_H - KSIZE + 1;
  localparam int DATA_W = 9;
  localparam int ACC_W  = 23;
  localparam int AW     = 13;
  localparam int PROD_W = 2 * DATA_W;
  localparam int NTAPS  = KSIZE * KSIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LAST  = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Offset of tap t from the patch's top-left pixel in a row-major strip of width w.
  function automatic logic [AW-1:0] tap_offset(input logic [3:0] t, input int w);
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = AW'(t / KSIZE);
    col = AW'(t % KSIZE);
    return row * AW'(w) + col;
  endfunction
endpackage

// File: rtl/dsp_block6_mul.sv
// rtl/dsp_block6_mul.sv - one dsp_block6 lane: signed 9x9 multiplier with clock enable and registered product
module dsp_block6_mul
  import dsp_block6_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      p <= '0;
    else if (ce)
      p <= a * b;
  end
endmodule

// File: rtl/dsp_block6_conv.sv
// rtl/dsp_block6_conv.sv - valid-mode 3x3 conv over strip 6, 12 cycles per output pixel
// Define STRIP6_RELU_EN to clamp negative results to zero before they are stored.
module dsp_block6_conv
  import dsp_block6_pkg::*;
#(
  parameter int STRIP_W = IMG_W,
  parameter int STRIP_H = IMG_H
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     kernel_read_complete,
  input  logic signed [DATA_W-1:0] kernel_0,
  input  logic signed [DATA_W-1:0] kernel_1,
  input  logic signed [DATA_W-1:0] kernel_2,
  input  logic signed [DATA_W-1:0] kernel_3,
  input  logic signed [DATA_W-1:0] kernel_4,
  input  logic signed [DATA_W-1:0] kernel_5,
  input  logic signed [DATA_W-1:0] kernel_6,
  input  logic signed [DATA_W-1:0] kernel_7,
  input  logic signed [DATA_W-1:0] kernel_8,
  input  logic                     in_we,
  input  logic [AW-1:0]            in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [AW-1:0]            strip6_addr,
  output logic                     done,
  output logic signed [ACC_W-1:0]  out
);
  localparam int SOUT_W    = STRIP_W - KSIZE + 1;
  localparam int SOUT_H    = STRIP_H - KSIZE + 1;
  localparam int MEM_DEPTH = 1 << AW;

  logic [2:0]               state;
  logic [3:0]               tap_cnt;
  logic [AW-1:0]            h;
  logic [AW-1:0]            v;
  logic [AW-1:0]            rd_addr;
  logic [AW-1:0]            wr_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] taps [NTAPS];
  logic signed [DATA_W-1:0] kern [NTAPS];
  logic signed [PROD_W-1:0] prod [NTAPS];
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  wr_data;
  logic                     mul_ce;
  logic                     out_we;

  logic signed [DATA_W-1:0] in_mem  [MEM_DEPTH];
  logic signed [ACC_W-1:0]  out_mem [MEM_DEPTH];

  assign kern = '{kernel_0, kernel_1, kernel_2, kernel_3, kernel_4,
                  kernel_5, kernel_6, kernel_7, kernel_8};

  assign rd_addr = v * AW'(STRIP_W) + h + tap_offset(tap_cnt, STRIP_W);
  assign wr_addr = v * AW'(SOUT_W) + h;
  assign mul_ce  = (state == S_MUL);
  assign out_we  = (state == S_ACC);

  // Loading is only allowed while idle so a running strip never sees its pixels change.
  always_ff @(posedge clk) begin
    if (in_we && state == S_IDLE)
      in_mem[in_addr] <= in_data;
    rd_data <= in_mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tap_cnt <= '0;
      h       <= '0;
      v       <= '0;
      for (int i = 0; i < NTAPS; i++)
        taps[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && kernel_read_complete) begin
            state   <= S_FETCH;
            tap_cnt <= '0;
            h       <= '0;
            v       <= '0;
          end
        end
        S_FETCH: begin
          // rd_data holds the tap addressed one cycle earlier
          if (tap_cnt != 4'd0)
            taps[tap_cnt - 4'd1] <= rd_data;
          if (tap_cnt == 4'(NTAPS - 1)) begin
            tap_cnt <= '0;
            state   <= S_LAST;
          end else begin
            tap_cnt <= tap_cnt + 4'd1;
          end
        end
        S_LAST: begin
          taps[NTAPS-1] <= rd_data;
          state         <= S_MUL;
        end
        S_MUL:
          state <= S_ACC;
        S_ACC: begin
          if (h == AW'(SOUT_W - 1)) begin
            h <= '0;
            if (v == AW'(SOUT_H - 1)) begin
              state <= S_DONE;
            end else begin
              v     <= v + AW'(1);
              state <= S_FETCH;
            end
          end else begin
            h     <= h + AW'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: ;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NTAPS; i++) begin : g_lane
    dsp_block6_mul u_mul (
      .clk   (clk),
      .reset (reset),
      .ce    (mul_ce),
      .a     (taps[i]),
      .b     (kern[i]),
      .p     (prod[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAPS; i++)
      sum = sum + ACC_W'(prod[i]);
  end

`ifdef STRIP6_RELU_EN
  assign wr_data = sum[ACC_W-1] ? '0 : sum;
`else
  assign wr_data = sum;
`endif

  always_ff @(posedge clk) begin
    if (out_we)
      out_mem[wr_addr] <= wr_data;
  end

  // Write-first: a read that collides with the ACC write returns the new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      out  <= (out_we && wr_addr == strip6_addr) ? wr_data : out_mem[strip6_addr];
      done <= (state == S_DONE);
    end
  end
endmodule

// File: tb/tb_dsp_block6_conv.sv
// tb/tb_dsp_block6_conv.sv - directed checks on a reduced 8x5 strip and one full 224x30 identity run
module tb_dsp_block6_conv;
  import dsp_block6_pkg::*;

  localparam int SW   = 8;
  localparam int SH   = 5;
  localparam int SOW  = SW - 2;
  localparam int SN   = SOW * (SH - 2);
  localparam int SLAT = 12 * SN + 1;
  localparam int FOW  = IMG_W - 2;
  localparam int FLAT = 12 * FOW * (IMG_H - 2) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     s_reset, s_start, s_krc, s_we, s_done;
  logic [AW-1:0]            s_addr, s_raddr;
  logic signed [DATA_W-1:0] s_data;
  logic signed [DATA_W-1:0] s_k [9];
  logic signed [ACC_W-1:0]  s_out;
  logic signed [DATA_W-1:0] s_pix [SW*SH];

  logic                     f_reset, f_start, f_krc, f_we, f_done;
  logic [AW-1:0]            f_addr, f_raddr;
  logic signed [DATA_W-1:0] f_data;
  logic signed [DATA_W-1:0] f_k [9];
  logic signed [ACC_W-1:0]  f_out;

  int errors = 0;
  int checks = 0;

  dsp_block6_conv #(.STRIP_W(SW), .STRIP_H(SH)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .kernel_read_complete(s_krc),
    .kernel_0(s_k[0]), .kernel_1(s_k[1]), .kernel_2(s_k[2]), .kernel_3(s_k[3]),
    .kernel_4(s_k[4]), .kernel_5(s_k[5]), .kernel_6(s_k[6]), .kernel_7(s_k[7]),
    .kernel_8(s_k[8]), .in_we(s_we), .in_addr(s_addr), .in_data(s_data),
    .strip6_addr(s_raddr), .done(s_done), .out(s_out)
  );

  dsp_block6_conv u_full (
    .clk(clk), .reset(f_reset), .start(f_start), .kernel_read_complete(f_krc),
    .kernel_0(f_k[0]), .kernel_1(f_k[1]), .kernel_2(f_k[2]), .kernel_3(f_k[3]),
    .kernel_4(f_k[4]), .kernel_5(f_k[5]), .kernel_6(f_k[6]), .kernel_7(f_k[7]),
    .kernel_8(f_k[8]), .in_we(f_we), .in_addr(f_addr), .in_data(f_data),
    .strip6_addr(f_raddr), .done(f_done), .out(f_out)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel a mod 256 read back as an 8-bit two's complement value.
  function automatic logic signed [DATA_W-1:0] sext8(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b[7], b};
  endfunction

  function automatic logic signed [63:0] s_exp(input int kind, input int idx);
    int v, h;
    v = idx / SOW;
    h = idx % SOW;
    case (kind)
      0: return 9;
      1: return 589824;
`ifdef STRIP6_RELU_EN
      2: return 0;
`else
      2: return -587520;
`endif
      default: return 45 * (v * SW + h) + 555;
    endcase
  endfunction

  function automatic logic signed [63:0] f_exp(input int idx);
    return 64'(sext8((idx / FOW + 1) * IMG_W + idx % FOW + 1));
  endfunction

  task automatic s_setup(input int kind);
    for (int t = 0; t < 9; t++)
      s_k[t] = (kind == 0) ? DATA_W'(1) : (kind == 3) ? DATA_W'(t + 1) : DATA_W'(-256);
    for (int i = 0; i < SW*SH; i++)
      s_pix[i] = (kind == 0) ? DATA_W'(1) : (kind == 1) ? DATA_W'(-256) :
                 (kind == 2) ? DATA_W'(255) : DATA_W'(i);
  endtask

  task automatic s_pulse_reset();
    @(negedge clk); s_reset = 1'b1; s_start = 1'b0;
    @(negedge clk); s_reset = 1'b0;
  endtask

  task automatic s_load();
    for (int i = 0; i < SW*SH; i++) begin
      @(negedge clk); s_we = 1'b1; s_addr = AW'(i); s_data = s_pix[i];
    end
    @(negedge clk); s_we = 1'b0;
  endtask

  task automatic s_run(output int cyc);
    @(negedge clk); s_start = 1'b1; s_krc = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!s_done && cyc < 4 * SLAT);
    @(negedge clk); s_start = 1'b0;
  endtask

  task automatic s_verify(input string tag, input int kind);
    for (int i = 0; i < SN; i++) begin
      @(negedge clk); s_raddr = AW'(i);
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tag, i), s_out, s_exp(kind, i));
    end
  endtask

  task automatic f_check_idx(input int idx);
    @(negedge clk); f_raddr = AW'(idx);
    @(posedge clk); #1;
    check($sformatf("full_identity[%0d]", idx), f_out, f_exp(idx));
  endtask

  initial begin
    int cyc;
    string names [4] = '{"ones", "neg_neg", "pos_neg", "ramp"};
    s_reset = 1'b1; s_start = 1'b0; s_krc = 1'b0; s_we = 1'b0;
    s_addr = '0; s_raddr = '0; s_data = '0;
    f_reset = 1'b1; f_start = 1'b0; f_krc = 1'b0; f_we = 1'b0;
    f_addr = '0; f_raddr = '0; f_data = '0;
    for (int t = 0; t < 9; t++) begin
      s_k[t] = '0;
      f_k[t] = (t == 4) ? DATA_W'(1) : DATA_W'(0);
    end
    repeat (2) @(negedge clk);
    check("reset_done", s_done, 0);
    check("reset_out", s_out, 0);
    check("reset_full_done", f_done, 0);
    check("reset_full_out", f_out, 0);
    s_reset = 1'b0;
    f_reset = 1'b0;

    for (int kind = 0; kind < 4; kind++) begin
      s_setup(kind);
      s_pulse_reset();
      s_load();
      s_run(cyc);
      check({names[kind], "_latency"}, cyc, SLAT);
      s_verify(names[kind], kind);
    end

    s_setup(0);
    s_pulse_reset();
    s_load();
    @(negedge clk); s_start = 1'b1; s_krc = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("stall_done", s_done, 0);
    s_run(cyc);
    check("stall_latency", cyc, SLAT);
    s_verify("stall", 0);

    s_setup(3);
    s_pulse_reset();
    s_load();
    @(negedge clk); s_raddr = '0; s_start = 1'b1; s_krc = 1'b1;
    repeat (12 * 10) @(posedge clk);
    #2; s_reset = 1'b1;
    #1;
    check("midrun_done", s_done, 0);
    check("midrun_out", s_out, 0);
    @(negedge clk); s_reset = 1'b0; s_start = 1'b0;
    s_run(cyc);
    check("restart_latency", cyc, SLAT);
    s_verify("restart", 3);

    @(negedge clk); f_reset = 1'b1;
    @(negedge clk); f_reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        int a;
        a = ((r < 3) ? r : r + 24) * IMG_W + c;
        @(negedge clk); f_we = 1'b1; f_addr = AW'(a); f_data = sext8(a);
      end
    end
    @(negedge clk); f_we = 1'b0; f_start = 1'b1; f_krc = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!f_done && cyc < FLAT + 100);
    check("full_latency", cyc, 74593);
    @(negedge clk); f_raddr = '0;
    @(posedge clk); #1;
    check("full_idx0", f_out, -31);
    f_check_idx(FOW - 1);
    f_check_idx(27 * FOW);
    f_check_idx(28 * FOW - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
